// File: rtl/rv_ifu.sv
// Instruction fetch loop REQ -> WAIT -> OUT with one imem request outstanding; minimum 3 cycles per instruction.
// Holds imem request while imem_req_ready=0 and IF_ID message while id_if_ready=0; redirects win and squash in-flight fetches.
module rv_ifu #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [WIDTH-1:0]   imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic [2*WIDTH-1:0] IF_ID_message,
  output logic               if_id_valid,
  input  logic               id_if_ready,
  output logic [31:0]        fetch_cnt
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   req_addr_q, req_addr_d;
  logic               kill_q, kill_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] msg_q, msg_d;
  logic [31:0]        fetch_cnt_q, fetch_cnt_d;
  logic [WIDTH-1:0]   redir_tgt;

  assign redir_tgt      = {redirect_pc[WIDTH-1:2], 2'b00};
  assign imem_req_valid = rst & (state_q == S_REQ);
  assign imem_addr      = req_addr_q;
  assign if_id_valid    = rst & out_valid_q & ~redirect_valid;
  assign IF_ID_message  = msg_q;
  assign fetch_cnt      = fetch_cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    kill_d      = kill_q;
    out_valid_d = out_valid_q;
    msg_d       = msg_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      S_REQ: begin
        // A redirect cannot retract the presented request; its response is dropped later.
        if (redirect_valid) begin
          pc_d   = redir_tgt;
          kill_d = 1'b1;
        end
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (redirect_valid) begin
            pc_d       = redir_tgt;
            req_addr_d = redir_tgt;
          end else if (kill_q) begin
            req_addr_d = pc_q;
          end else begin
            msg_d       = {req_addr_q, imem_rsp_data};
            out_valid_d = 1'b1;
            pc_d        = req_addr_q + WIDTH'(4);
            state_d     = S_OUT;
          end
        end else if (redirect_valid) begin
          pc_d   = redir_tgt;
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          pc_d        = redir_tgt;
          req_addr_d  = redir_tgt;
          state_d     = S_REQ;
        end else if (id_if_ready) begin
          out_valid_d = 1'b0;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          req_addr_d  = pc_q;
          state_d     = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      msg_q       <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      msg_q       <= msg_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_ifu.sv
// Bench for rv_ifu: directed scenarios then random traffic, checked against a transaction-level fetch model.
module tb_rv_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] IF_ID_message;
  logic        if_id_valid;
  logic        id_if_ready;
  logic [31:0] fetch_cnt;

  rv_ifu #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .IF_ID_message  (IF_ID_message),
    .if_id_valid    (if_id_valid),
    .id_if_ready    (id_if_ready),
    .fetch_cnt      (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Fetch model: messages owed to the IDU, the address the next fresh fetch must use,
  // and whether the fetch in flight has been squashed by a redirect.
  logic [63:0] exp_q[$];
  logic [31:0] next_addr, cur_addr, mem_addr, exp_cnt;
  bit          taint, in_flight, req_pend, mem_out, cnt_known;
  bit          data_mode, spur_en;
  int          mem_wait, mem_lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return data_mode ? (a ^ 32'h5A5A_1234) : 32'h0000_0013;
  endfunction

  task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc, input bit frsp);
    bit exp_req, exp_ifv;
    imem_req_ready = rdy;
    id_if_ready    = idr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_out) begin
      mem_wait--;
      if (mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(mem_addr);
      end
    end else if (spur_en && $urandom_range(7) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    if (frsp) imem_rsp_valid = 1'b1;

    @(negedge clk);
    exp_req = rst && !mem_out && exp_q.size() == 0;
    exp_ifv = rst && exp_q.size() != 0 && !redir;
    check("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_req});
    if (exp_req && imem_req_valid)
      check("req_addr", {32'd0, imem_addr}, {32'd0, req_pend ? cur_addr : next_addr});
    check("if_id_valid", {63'd0, if_id_valid}, {63'd0, exp_ifv});
    if (exp_ifv) check("message", IF_ID_message, exp_q[0]);
    if (cnt_known) check("fetch_cnt", {32'd0, fetch_cnt}, {32'd0, exp_cnt});

    if (!rst) begin
      exp_q.delete();
      next_addr = RST_PC;
      exp_cnt   = 32'd0;
      taint     = 1'b0;
      in_flight = 1'b0;
      req_pend  = 1'b0;
      mem_out   = 1'b0;
      cnt_known = 1'b1;
    end else begin
      if (imem_req_valid && !req_pend) begin
        cur_addr  = imem_addr;
        taint     = 1'b0;
        in_flight = 1'b1;
      end
      req_pend = imem_req_valid && !rdy;
      if (redir) begin
        next_addr = {rpc[31:2], 2'b00};
        if (in_flight) taint = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (imem_rsp_valid && mem_out) begin
        mem_out   = 1'b0;
        in_flight = 1'b0;
        if (!taint && !redir) begin
          exp_q.push_back({cur_addr, mem_data(cur_addr)});
          next_addr = cur_addr + 32'd4;
        end
      end
      if (imem_req_valid && rdy) begin
        mem_out  = 1'b1;
        mem_addr = imem_addr;
        mem_wait = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
      end
      if (exp_ifv && idr) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b0; imem_req_ready = 1'b0; id_if_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    cnt_known = 1'b0; mem_out = 1'b0; req_pend = 1'b0; taint = 1'b0; in_flight = 1'b0;
    next_addr = RST_PC; cur_addr = RST_PC; mem_addr = 32'd0; exp_cnt = 32'd0;
    data_mode = 1'b0; spur_en = 1'b0; mem_lat = 1; mem_wait = 0;

    do_reset(3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check("two_fetch_cnt", {32'd0, fetch_cnt}, 64'd2);

    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check("stall_cnt", {32'd0, fetch_cnt}, 64'd3);

    do_reset(2);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("held_addr", {32'd0, imem_addr}, {32'd0, RST_PC});
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check("after_kill_addr", {32'd0, imem_addr}, 64'h8000_0100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    for (int k = 0; k < 8 && !mem_out; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check("reach_wait", {63'd0, mem_out}, 64'd1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0203, 1'b0);
    check("rsp_redir_addr", {32'd0, imem_addr}, 64'h8000_0200);
    check("rsp_redir_valid", {63'd0, if_id_valid}, 64'd0);

    for (int k = 0; k < 8 && exp_q.size() == 0; k++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("reach_out", {63'd0, exp_q.size() != 0}, 64'd1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0400, 1'b0);
    check("out_redir_addr", {32'd0, imem_addr}, 64'h8000_0400);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    mem_lat = 3;
    for (int k = 0; k < 8 && !mem_out; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check("reach_wait2", {63'd0, mem_out}, 64'd1);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    rst = 1'b1;
    check("rst_addr", {32'd0, imem_addr}, {32'd0, RST_PC});
    check("rst_ifv", {63'd0, if_id_valid}, 64'd0);
    check("rst_cnt", {32'd0, fetch_cnt}, 64'd0);

    mem_lat = 0; data_mode = 1'b1; spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                         rpc = 32'h8000_0000 | ($urandom & 32'hFFF);
      step(bit'($urandom_range(3) != 0), bit'($urandom_range(3) != 0),
           bit'($urandom_range(15) == 0), rpc, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_ifu.md
RV_IFU -- requirements
Module: rv_IFU

Interface
REQ-001 Parameter WIDTH, default 32, data/address width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_addr  out  WIDTH  fetch address, word aligned.
REQ-008 imem_rsp_valid  in  1  response valid, one cycle pulse.
REQ-009 imem_rsp_data  in  WIDTH  fetched instruction.
REQ-010 redirect_valid  in  1  branch/jump redirect from EXU.
REQ-011 redirect_pc  in  WIDTH  redirect target.
REQ-012 IF_ID_message  out  `IF_ID_WIDTH  {pc, inst}, pc in upper 32 bits, inst in lower 32 bits.
REQ-013 if_id_valid  out  1  IF_ID_message valid to IDU.
REQ-014 id_if_ready  in  1  IDU accepts message.
REQ-015 fetch_cnt  out  32  count of instructions delivered to IDU.

Function
REQ-016 Block SHALL implement FSM states REQ, WAIT, OUT; reset state REQ.
REQ-017 REQ: imem_req_valid=1, imem_addr=req_addr; on imem_req_valid&imem_req_ready -> WAIT.
REQ-018 req_addr SHALL be loaded from pc on entry to REQ and held stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 WAIT: imem_req_valid=0; on imem_rsp_valid with kill=0 -> register {req_addr, imem_rsp_data} into IF_ID_message, pc<=req_addr+4, -> OUT.
REQ-020 WAIT: on imem_rsp_valid with kill=1 -> discard data, kill<=0, -> REQ, pc unchanged.
REQ-021 OUT: if_id_valid = out_valid & ~redirect_valid; IF_ID_message held stable until handshake.
REQ-022 OUT: on if_id_valid&id_if_ready -> out_valid<=0, fetch_cnt<=fetch_cnt+1, -> REQ next cycle.
REQ-023 Only one request outstanding; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-024 Minimum loop latency: REQ accepted cycle N, response cycle N+1, if_id_valid cycle N+2, next imem_req_valid cycle N+3 after handshake at N+2.
REQ-025 redirect_valid SHALL have priority over every other event; pc<=redirect_pc with bits [1:0] forced to 2'b00.
REQ-026 Redirect in REQ: in-flight/pending request completes with its held address; kill<=1.
REQ-027 Redirect in WAIT without imem_rsp_valid: kill<=1.
REQ-028 Redirect in WAIT with simultaneous imem_rsp_valid: response discarded, kill<=0, -> REQ.
REQ-029 Redirect in OUT: no handshake occurs that cycle, out_valid<=0, fetch_cnt unchanged, -> REQ.
REQ-030 Repeated redirects while kill=1: pc updated to latest redirect_pc; kill stays 1; only one response dropped.
REQ-031 pc+4 and fetch_cnt+1 SHALL wrap modulo 2^32 without flag.

Reset
REQ-032 On rst=0 at posedge: state=REQ, pc=RESET_PC, kill=0, out_valid=0, IF_ID_message=0, fetch_cnt=0.
REQ-033 During reset imem_req_valid=0 and if_id_valid=0; first imem_req_valid=1 with imem_addr=RESET_PC in first cycle after rst deasserts.
REQ-034 Reset mid-WAIT SHALL abandon the outstanding request; imem is reset by the same rst.

Verification
REQ-035 Reset release, imem always ready, rsp 1 cycle later with 32'h00000013, id_if_ready=1 -> messages {8000_0000,0000_0013}, {8000_0004,0000_0013}, fetch_cnt=2 after second handshake.
REQ-036 id_if_ready=0 for 5 cycles in OUT -> IF_ID_message stable, no new imem_req_valid, fetch_cnt unchanged; accept on cycle 6 -> fetch_cnt+1.
REQ-037 imem_req_ready=0 for 3 cycles with redirect_pc=32'h8000_0100 in cycle 2 -> imem_addr stays 8000_0000 until accept; that response dropped; next request addr 8000_0100.
REQ-038 Redirect to 32'h8000_0203 same cycle as imem_rsp_valid in WAIT -> no message delivered; next imem_addr=8000_0200.
REQ-039 Redirect in OUT with id_if_ready=1 -> if_id_valid=0 that cycle, fetch_cnt unchanged, next fetch at redirect target.
REQ-040 rst=0 asserted in WAIT, rsp arrives during reset -> ignored; after release imem_addr=RESET_PC, if_id_valid=0, fetch_cnt=0.
